// File: rtl/inst_loader_if.sv
// inst_loader_if: byte-stream, instruction-memory write and status signals of the program loader
//   master : loader side (consumes bytes, drives the write port and status)
//   slave  : host/bench side (drives bytes and start, observes everything else)
//   start        one-cycle re-arm pulse
//   byte_valid   byte_data valid this cycle
//   byte_data    stream byte
//   byte_ready   loader accepts a byte this cycle
//   tb_we        one-cycle instruction-memory write strobe
//   tb_addr      word-aligned write byte address
//   tb_inst      write data
//   cpu_reset_n  active-low reset to the core
//   done         image loaded (level)
//   error        image rejected (level)
interface inst_loader_if;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        tb_we;
    logic [31:0] tb_addr;
    logic [31:0] tb_inst;
    logic        cpu_reset_n;
    logic        done;
    logic        error;
    modport master (
        input  start, byte_valid, byte_data,
        output byte_ready, tb_we, tb_addr, tb_inst, cpu_reset_n, done, error
    );
    modport slave (
        output start, byte_valid, byte_data,
        input  byte_ready, tb_we, tb_addr, tb_inst, cpu_reset_n, done, error
    );
endinterface

// File: rtl/inst_loader.sv
// inst_loader: assembles a little-endian byte stream into a program image and writes it to instruction memory
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    inst_loader_if.master (byte stream in, tb_we/tb_addr/tb_inst out, cpu_reset_n/done/error)
//   Stream format: 4-byte word count N, then N data words.
//   Optional macro LOADER_CHECKSUM_EN: a trailing 4-byte word must equal the modulo-2^32 sum of the data words.
module inst_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic          clk,
    input  logic          reset,
    inst_loader_if.master bus
);
    localparam logic [2:0] S_LEN  = 3'd0;
    localparam logic [2:0] S_DATA = 3'd1;
    localparam logic [2:0] S_SUM  = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]  r_state;
    logic [1:0]  r_idx;
    logic [23:0] r_bytes;
    logic [31:0] r_len;
    logic [31:0] r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_inst;
    logic        r_we;
    logic        r_done;
    logic        r_err;
    logic        r_rstn;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] r_sum;
`endif

    logic        w_ready;
    logic        w_accept;
    logic        w_last;
    logic        w_rearm;
    logic        w_final;
    logic [31:0] w_word;

    assign w_ready  = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_SUM);
    assign w_accept = bus.byte_valid && w_ready;
    assign w_last   = w_accept && (r_idx == 2'd3);
    // earlier bytes sit in a shift register, so the incoming byte completes the word
    assign w_word   = {bus.byte_data, r_bytes};
    assign w_rearm  = bus.start && ((r_state == S_DONE) || (r_state == S_ERR));
    assign w_final  = (r_cnt == r_len - 32'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_LEN;
            r_idx   <= 2'd0;
            r_bytes <= 24'd0;
            r_len   <= 32'd0;
            r_cnt   <= 32'd0;
            r_addr  <= BASE_ADDR;
            r_inst  <= 32'd0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rstn  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_sum   <= 32'd0;
`endif
        end else begin
            r_we   <= 1'b0;
            // status follows the state one cycle later, so cpu_reset_n never rises with the last strobe
            r_done <= (r_state == S_DONE) && !bus.start;
            r_rstn <= (r_state == S_DONE) && !bus.start;
            r_err  <= (r_state == S_ERR) && !bus.start;
            if (w_rearm) begin
                r_state <= S_LEN;
                r_idx   <= 2'd0;
                r_bytes <= 24'd0;
                r_len   <= 32'd0;
                r_cnt   <= 32'd0;
                r_addr  <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
                r_sum   <= 32'd0;
`endif
            end else if (w_accept) begin
                r_idx   <= r_idx + 2'd1;
                r_bytes <= {bus.byte_data, r_bytes[23:8]};
                if (w_last) begin
                    case (r_state)
                        S_LEN: begin
                            if (w_word == 32'd0 || w_word > 32'(MAX_WORDS)) r_state <= S_ERR;
                            else begin
                                r_len   <= w_word;
                                r_state <= S_DATA;
                            end
                        end
                        S_DATA: begin
                            r_we   <= 1'b1;
                            r_inst <= w_word;
                            r_addr <= BASE_ADDR + {r_cnt[29:0], 2'b00};
                            r_cnt  <= r_cnt + 32'd1;
`ifdef LOADER_CHECKSUM_EN
                            r_sum  <= r_sum + w_word;
                            if (w_final) r_state <= S_SUM;
`else
                            if (w_final) r_state <= S_DONE;
`endif
                        end
`ifdef LOADER_CHECKSUM_EN
                        S_SUM: r_state <= (w_word == r_sum) ? S_DONE : S_ERR;
`endif
                        default: r_state <= r_state;
                    endcase
                end
            end
        end
    end

    assign bus.byte_ready  = w_ready;
    assign bus.tb_we       = r_we;
    assign bus.tb_addr     = r_addr;
    assign bus.tb_inst     = r_inst;
    assign bus.cpu_reset_n = r_rstn;
    assign bus.done        = r_done;
    assign bus.error       = r_err;
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed self-checking bench for inst_loader
module tb_inst_loader;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    inst_loader_if bus ();

    inst_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int   cyc = 0;
    int   last_we_cyc = -1;
    int   done_rise = -1;
    int   rstn_rise = -1;
    int   width_err = 0;
    logic prev_we = 1'b0;
    logic prev_done = 1'b0;
    logic prev_rstn = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (bus.tb_we === 1'b1) begin
            wa.push_back(bus.tb_addr);
            wd.push_back(bus.tb_inst);
            last_we_cyc = cyc;
            if (prev_we) width_err++;
        end
        if (bus.done === 1'b1 && !prev_done) done_rise = cyc;
        if (bus.cpu_reset_n === 1'b1 && !prev_rstn) rstn_rise = cyc;
        prev_we   = (bus.tb_we === 1'b1);
        prev_done = (bus.done === 1'b1);
        prev_rstn = (bus.cpu_reset_n === 1'b1);
    end

    task automatic clear_log();
        wa.delete();
        wd.delete();
        last_we_cyc = -1;
        done_rise = -1;
        rstn_rise = -1;
        width_err = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_log();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        n = 0;
        while (bus.byte_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) begin
            failures++;
            $display("FAIL byte_accept_timeout got ready=%b want 1", bus.byte_ready);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps ? int'($urandom_range(0, 5)) : 0);
    endtask

    task automatic test_reset();
        do_reset();
        checks += 7;
        if (bus.byte_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got %b want 1", bus.byte_ready); end
        if (bus.tb_we !== 1'b0) begin failures++; $display("FAIL rst_we got %b want 0", bus.tb_we); end
        if (bus.tb_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got %h want 0", bus.tb_addr); end
        if (bus.tb_inst !== 32'h0) begin failures++; $display("FAIL rst_inst got %h want 0", bus.tb_inst); end
        if (bus.cpu_reset_n !== 1'b0) begin failures++; $display("FAIL rst_cpu_reset_n got %b want 0", bus.cpu_reset_n); end
        if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done got %b want 0", bus.done); end
        if (bus.error !== 1'b0) begin failures++; $display("FAIL rst_error got %b want 0", bus.error); end
    endtask

    task automatic check_two_writes(input string tag);
        checks += 2;
        if (wa.size() != 2) begin
            failures++;
            $display("FAIL %s_count got %0d want 2", tag, wa.size());
        end else begin
            if (wa[0] !== 32'h0 || wd[0] !== 32'h0000_0013) begin
                failures++; $display("FAIL %s_w0 got %h/%h want 00000000/00000013", tag, wa[0], wd[0]);
            end
            if (wa[1] !== 32'h4 || wd[1] !== 32'h0010_0093) begin
                failures++; $display("FAIL %s_w1 got %h/%h want 00000004/00100093", tag, wa[1], wd[1]);
            end
        end
    endtask

    task automatic test_basic();
        do_reset();
        send_word(32'd2, 1'b0);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0010_0093, 1'b0);
        repeat (3) @(negedge clk);
        check_two_writes("basic");
        checks += 6;
        if (done_rise != last_we_cyc + 1) begin failures++; $display("FAIL basic_done_timing got %0d want %0d", done_rise, last_we_cyc + 1); end
        if (rstn_rise != last_we_cyc + 1) begin failures++; $display("FAIL basic_rstn_timing got %0d want %0d", rstn_rise, last_we_cyc + 1); end
        if (bus.done !== 1'b1) begin failures++; $display("FAIL basic_done got %b want 1", bus.done); end
        if (bus.cpu_reset_n !== 1'b1) begin failures++; $display("FAIL basic_cpu_reset_n got %b want 1", bus.cpu_reset_n); end
        if (bus.byte_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_done got %b want 0", bus.byte_ready); end
        if (width_err != 0) begin failures++; $display("FAIL basic_we_width got %0d want 0", width_err); end
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hAA;
        repeat (4) @(negedge clk);
        bus.byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks += 2;
        if (wa.size() != 2) begin failures++; $display("FAIL extra_bytes_writes got %0d want 2", wa.size()); end
        if (bus.done !== 1'b1) begin failures++; $display("FAIL extra_bytes_done got %b want 1", bus.done); end
    endtask

    task automatic test_restart();
        clear_log();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checks += 4;
        if (bus.done !== 1'b0) begin failures++; $display("FAIL restart_done got %b want 0", bus.done); end
        if (bus.cpu_reset_n !== 1'b0) begin failures++; $display("FAIL restart_rstn got %b want 0", bus.cpu_reset_n); end
        if (bus.tb_addr !== 32'h0) begin failures++; $display("FAIL restart_addr got %h want 0", bus.tb_addr); end
        if (bus.byte_ready !== 1'b1) begin failures++; $display("FAIL restart_ready got %b want 1", bus.byte_ready); end
        send_word(32'd1, 1'b0);
        send_word(32'h0000_0073, 1'b0);
        repeat (3) @(negedge clk);
        checks += 2;
        if (wa.size() != 1 || wa[0] !== 32'h0 || wd[0] !== 32'h0000_0073) begin
            failures++; $display("FAIL restart_write got n=%0d %h/%h want 1 00000000/00000073", wa.size(), wa.size() ? wa[0] : 32'hx, wd.size() ? wd[0] : 32'hx);
        end
        if (bus.done !== 1'b1) begin failures++; $display("FAIL restart_done_again got %b want 1", bus.done); end
    endtask

    task automatic test_gaps();
        do_reset();
        send_word(32'd2, 1'b1);
        send_word(32'h0000_0013, 1'b1);
        send_word(32'h0010_0093, 1'b1);
        repeat (3) @(negedge clk);
        check_two_writes("gaps");
        checks += 2;
        if (width_err != 0) begin failures++; $display("FAIL gaps_we_width got %0d want 0", width_err); end
        if (bus.done !== 1'b1) begin failures++; $display("FAIL gaps_done got %b want 1", bus.done); end
    endtask

    task automatic test_bad_len(input logic [31:0] len, input string tag);
        do_reset();
        send_word(len, 1'b0);
        repeat (3) @(negedge clk);
        checks += 5;
        if (bus.error !== 1'b1) begin failures++; $display("FAIL %s_error got %b want 1", tag, bus.error); end
        if (wa.size() != 0) begin failures++; $display("FAIL %s_writes got %0d want 0", tag, wa.size()); end
        if (bus.cpu_reset_n !== 1'b0) begin failures++; $display("FAIL %s_rstn got %b want 0", tag, bus.cpu_reset_n); end
        if (bus.byte_ready !== 1'b0) begin failures++; $display("FAIL %s_ready got %b want 0", tag, bus.byte_ready); end
        if (bus.done !== 1'b0) begin failures++; $display("FAIL %s_done got %b want 0", tag, bus.done); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_word(32'd2, 1'b0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        do_reset();
        send_word(32'd1, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        repeat (3) @(negedge clk);
        checks += 2;
        if (wa.size() != 1 || wa[0] !== 32'h0 || wd[0] !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL midreset_write got n=%0d %h/%h want 1 00000000/deadbeef", wa.size(), wa.size() ? wa[0] : 32'hx, wd.size() ? wd[0] : 32'hx);
        end
        if (bus.done !== 1'b1) begin failures++; $display("FAIL midreset_done got %b want 1", bus.done); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum(input logic [31:0] trailer, input bit ok, input string tag);
        do_reset();
        send_word(32'd2, 1'b0);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(trailer, 1'b0);
        repeat (3) @(negedge clk);
        checks += 3;
        if (wa.size() != 2) begin failures++; $display("FAIL %s_writes got %0d want 2", tag, wa.size()); end
        if (bus.done !== ok) begin failures++; $display("FAIL %s_done got %b want %b", tag, bus.done, ok); end
        if (bus.error !== !ok) begin failures++; $display("FAIL %s_error got %b want %b", tag, bus.error, !ok); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'h00;
        test_reset();
        test_basic();
        test_restart();
        test_gaps();
        test_bad_len(32'd0, "len0");
        test_bad_len(32'd257, "lenmax");
        test_mid_reset();
`ifdef LOADER_CHECKSUM_EN
        test_checksum(32'd3, 1'b1, "sum_ok");
        test_checksum(32'd4, 1'b0, "sum_bad");
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Upstream of the pipelined RV32I core.
- Receives a byte stream carrying a program image, assembles little-endian 32-bit words, and drives them into the core's instruction-memory write port (tb_addr/tb_inst/tb_we).
- Holds the core in reset until the image has loaded cleanly.
- Sits between the bench or host byte source and the CPU top level.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction word written.
- MAX_WORDS, 256, maximum accepted word count; a larger header count is an error.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; re-arms the loader from DONE or ERR
- byte_valid  input  1  byte_data is valid this cycle
- byte_data  input  8  stream byte
- byte_ready  output  1  loader accepts a byte this cycle
- tb_we  output  1  one-cycle instruction-memory write strobe
- tb_addr  output  32  write byte address, word aligned
- tb_inst  output  32  write data
- cpu_reset_n  output  1  active-low reset to the core
- done  output  1  image loaded successfully (level)
- error  output  1  image rejected (level)

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values:
  - state=LEN; byte_ready=1; tb_we=0; tb_addr=BASE_ADDR; tb_inst=0.
  - cpu_reset_n=0; done=0; error=0.
  - Byte index, word counter and length register all 0.
- Handshake:
  - A byte transfers on a clk edge where byte_valid && byte_ready.
  - byte_ready=1 only in LEN, DATA and SUM; 0 in DONE and ERR.
- Byte assembly:
  - A 2-bit index counts 0..3; byte k is placed at bits [8k+7:8k].
  - The index wraps to 0 after the 4th byte.
- States and transitions:
  - LEN: assemble the 4-byte word count N. On the 4th byte:
    - N==0 or N>MAX_WORDS -> ERR.
    - Otherwise latch N and go to DATA.
  - DATA: on each 4th byte, the next cycle drives tb_we=1 for exactly one cycle, with tb_inst=the assembled word and tb_addr=BASE_ADDR+4*i (i = 0-based word index).
  - DATA, after word N-1 is written:
    - Go to DONE.
    - With LOADER_CHECKSUM_EN, go to SUM instead.
  - DONE: done=1, cpu_reset_n=1. Extra byte_valid is ignored (byte_ready=0).
  - ERR: error=1, cpu_reset_n=0, no further writes.
  - start in DONE or ERR:
    - Next cycle: state=LEN, done=0, error=0, cpu_reset_n=0.
    - Counters clear; tb_addr=BASE_ADDR.
  - start in LEN, DATA or SUM is ignored.
- Latency: 1 cycle from acceptance of a word's 4th byte to the tb_we pulse.
- Throughput: one byte per cycle; back-to-back words give a tb_we pulse every 4 cycles.
- cpu_reset_n rises the cycle after entering DONE, i.e. after the last tb_we has been issued, never in the same cycle as it.
- tb_addr arithmetic:
  - 32-bit, wraps modulo 2^32.
  - tb_addr holds its last value between strobes.
- Reset mid-load: asynchronous return to reset values. Partial words are discarded and no tb_we is issued.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After N data words, state SUM assembles one more 4-byte word, which is not written to memory.
  - It is compared with the 32-bit modulo sum of all N data words.
  - Equal -> DONE; unequal -> ERR.
  - The running sum is cleared on reset and on start.
- Not defined: no SUM state, no sum register; DATA goes directly to DONE.

Test Plan:
- Reset, then stream len=2 (02 00 00 00), 13 00 00 00, 93 00 10 00 -> exactly two tb_we pulses:
  - addr 0x0 with data 0x00000013;
  - addr 0x4 with data 0x00100093.
  - Then done=1 and cpu_reset_n=1 one cycle after the second pulse.
- Header len=0, and separately len=MAX_WORDS+1 -> error=1, no tb_we ever, cpu_reset_n stays 0, byte_ready=0.
- byte_valid toggled randomly, with gaps of 0-5 cycles between bytes -> identical write sequence; tb_we width always 1 cycle.
- Assert reset after 2 bytes of word 1, then reload len=1 with word 0xDEADBEEF -> single write, 0xDEADBEEF at BASE_ADDR; no stale partial data.
- After done, pulse start and load len=1 with word 0x00000073 -> done drops, cpu_reset_n=0, write at BASE_ADDR, then done=1 again.
- With LOADER_CHECKSUM_EN, len=2 with words 0x1 and 0x2:
  - trailer 0x3 -> done=1;
  - trailer 0x4 -> error=1.
  - In both cases tb_we pulses only twice.
